// File: rtl/vs_ram_port_arbiter.sv
// vs_ram_port_arbiter
//   Round-robin arbiter sharing one single-clock synchronous RAM among
//   NUM_PORTS requesters. At most one access (read or write) is issued per
//   clock. Read data returns one cycle after the grant, tagged with a one-hot
//   rsp_valid. A requester holding req_lock keeps the RAM for up to MAX_BURST
//   consecutive grants.
//
// Ports
//   clock, reset_n      shared rising-edge clock, async active-low reset
//   req_valid/write/lock  per-port request bits
//   req_addr, req_wdata   flattened per-port address / write data slices
//   req_ready           one-hot grant (accepted when valid && ready)
//   rsp_valid, rsp_data one-hot read response tag and shared read data
//   ram_*               RAM write_enable, write_addr, read_addr, in_data, out_data
module vs_ram_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS-1:0]             req_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             ram_write_enable,
    output logic [ADDR_WIDTH-1:0]            ram_write_addr,
    output logic [ADDR_WIDTH-1:0]            ram_read_addr,
    output logic [DATA_WIDTH-1:0]            ram_in_data,
    input  logic [DATA_WIDTH-1:0]            ram_out_data
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = 4;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        owner;
    logic                 owner_vld;
    logic [CW-1:0]        burst_cnt;
    logic [NUM_PORTS-1:0] rd_tag;

    logic                 lock_hold;
    logic                 grant_any;
    logic [PW-1:0]        grant_idx;
    logic [NUM_PORTS-1:0] grant_oh;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                 sel_write;

    // Grant selection. A held lock wins outright; otherwise scan from rr_ptr.
    // The scan walks offsets from farthest to nearest so the nearest valid
    // port (lowest offset from rr_ptr) is the one left standing.
    always_comb begin
        int p;
        p         = 0;
        lock_hold = owner_vld && req_valid[owner] && req_lock[owner] &&
                    (burst_cnt < CW'(MAX_BURST - 1));
        grant_any = 1'b0;
        grant_idx = '0;
        if (lock_hold) begin
            grant_any = 1'b1;
            grant_idx = owner;
        end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                p = int'(rr_ptr) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
                if (req_valid[p]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(p);
                end
            end
        end
        // Reset forces every output quiet immediately, not at the next edge.
        if (!reset_n) begin
            grant_any = 1'b0;
            lock_hold = 1'b0;
        end
    end

    assign grant_oh  = grant_any ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_write = req_write[grant_idx];

    assign req_ready        = grant_oh;
    assign ram_write_enable = grant_any && sel_write;
    assign ram_write_addr   = (grant_any && sel_write)  ? sel_addr  : '0;
    assign ram_in_data      = (grant_any && sel_write)  ? sel_wdata : '0;
    assign ram_read_addr    = (grant_any && !sel_write) ? sel_addr  : '0;

    // The RAM read is registered, so the tag captured at the grant edge lines
    // up with ram_out_data in the following cycle.
    assign rsp_valid = rd_tag;
    assign rsp_data  = reset_n ? ram_out_data : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
            rd_tag    <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
            // Ownership only survives while the granted port keeps asking for
            // the lock; dropping valid frees the RAM for round robin.
            owner     <= grant_idx;
            owner_vld <= grant_any && req_lock[grant_idx];
            burst_cnt <= lock_hold ? burst_cnt + 1'b1 : '0;
            rd_tag    <= (grant_any && !sel_write) ? grant_oh : '0;
        end
    end

endmodule

// File: doc/vs_ram_port_arbiter.md
# vs_ram_port_arbiter

Round-robin arbiter that shares one `vs_single_clock_synchronous_ram` among `NUM_PORTS` requesters, issuing at most one access (read or write) per clock. It drives the RAM's write-enable, write address, read address and input data, and routes read data back to the winning requester after the RAM's one-cycle registered-read latency. A burst-lock option lets a requester hold the RAM for up to `MAX_BURST` consecutive accesses. It sits between memory clients (DMA, CPU-side loaders, test harnesses) and the RAM instance.

## Interface

Parameters:
- `NUM_PORTS`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 16: RAM address width.
- `DATA_WIDTH`, default 8: RAM data width.
- `MAX_BURST`, default 4: maximum consecutive grants to one locked port, 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock shared with the RAM.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_PORTS  per-port request valid.
- `req_write`  in  NUM_PORTS  1 = write, 0 = read.
- `req_lock`  in  NUM_PORTS  request to keep the grant next cycle.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  per-port write data, sliced the same way.
- `req_ready`  out  NUM_PORTS  one-hot grant; the request is accepted when valid && ready.
- `rsp_valid`  out  NUM_PORTS  one-hot; read data for that port is on `rsp_data`.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all ports.
- `ram_write_enable`  out  1  to RAM `write_enable`.
- `ram_write_addr`  out  ADDR_WIDTH  to RAM `write_addr`.
- `ram_read_addr`  out  ADDR_WIDTH  to RAM `read_addr`.
- `ram_in_data`  out  DATA_WIDTH  to RAM `in_data`.
- `ram_out_data`  in  DATA_WIDTH  from RAM `out_data`.

## Operation

- **Arbitration.** `req_ready` is a combinational function of `req_valid` and the registered state (`rr_ptr`, `owner`, `burst_cnt`). It has at most one bit set, and never sets a bit whose `req_valid` is 0.
- **Round robin.** Search starts at `rr_ptr`, wrapping from NUM_PORTS-1 to 0. After a grant to port g, `rr_ptr` becomes (g+1) mod NUM_PORTS. If no port is granted, `rr_ptr` is unchanged.
- **Lock.** If the port granted in the last cycle still has `req_valid` && `req_lock` and `burst_cnt` < MAX_BURST-1, it is granted again and `burst_cnt` increments.
  - Otherwise `burst_cnt` clears to 0 and normal round robin applies from `rr_ptr`.
  - `owner` is valid only while a lock is held. A lock released by deasserting `req_valid` does not reserve the RAM.
- **Granted write.** `ram_write_enable`=1; `ram_write_addr` and `ram_in_data` are taken from the granted port.
- **Granted read.** `ram_read_addr` is the granted port's address; `ram_write_enable`=0.
- **No grant.** `ram_write_enable`=0; `ram_write_addr`, `ram_read_addr` and `ram_in_data` are 0.
- **Read response.** The registered one-hot `rd_tag` records which port's read was granted. Next cycle `rsp_valid`=`rd_tag` and `rsp_data`=`ram_out_data` (pass-through). After a write or idle cycle, `rd_tag`=0.
- **Reset.** While `reset_n`=0:
  - `req_ready`=0, `rsp_valid`=0, `ram_write_enable`=0, all address and data outputs 0.
  - `rr_ptr`=0, `burst_cnt`=0, no owner.
  - An in-flight read is discarded: no `rsp_valid` after reset is released.

## Timing

- Grant decision is same-cycle: request presented in cycle k, accepted at the rising edge ending cycle k.
- Write latency: RAM is updated at that edge. A read of the same address granted in cycle k+1 returns the new data.
- Read latency is 1 cycle: grant in cycle k means `rsp_valid` and valid `rsp_data` in cycle k+1. No response backpressure; clients must capture it.
- Throughput: one access per cycle, with back-to-back reads pipelined.
- A port holding valid waits at most (NUM_PORTS-1)*MAX_BURST cycles for a grant.
- Async reset asserts outputs immediately, not on the next edge. Deassertion is sampled at the next rising edge.

## Test plan

- **Reset.** Drive `reset_n`=0 mid-read; `rsp_valid` stays 0 and all outputs are 0. After release, all four ports request and port 0 is granted first.
- **Round robin.** Ports 0..3 issue continuous reads at addresses 0x10..0x13; grants follow 0,1,2,3,0 in consecutive cycles. Each `rsp_valid` is one-hot, one cycle later, with data matching the RAM contents.
- **Write then read.** Port 1 writes 0xA5 to 0x0040 in cycle k; port 2 reads 0x0040 in cycle k+1. `rsp_valid`[2]=1 in cycle k+2 with `rsp_data`=0xA5.
- **Burst lock.** With MAX_BURST=4, port 2 holds `req_lock` and `req_valid` while port 0 also requests. Port 2 gets 4 consecutive grants, then port 0 is granted.
- **Sparse requests.** Only port 3 is valid, then only port 0. Grants go 3 then 0, and there are no grants or writes in cycles with no valid.
- **Back-to-back writes.** Port 0 writes addresses 0..9 with data 0..9 over 10 cycles. Direct RAM inspection shows ram[i]==i.
